// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional even parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to compile in the even-parity bit; the default build has no parity.
module uart_tx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  tx,
  output logic                  busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W        = $clog2(DATA_WIDTH);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_baud;
  logic [BIT_W-1:0]      r_bit;
  logic                  r_stop;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_tx;
  logic                  r_busy;
`ifdef UART_TX_PARITY_EN
  logic                  r_parity;
`endif

  state_t                w_state_nxt;
  logic [CNT_W-1:0]      w_baud_nxt;
  logic [BIT_W-1:0]      w_bit_nxt;
  logic                  w_stop_nxt;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic                  w_tx_nxt;
  logic                  w_busy_nxt;
  logic                  w_accept;
  logic                  w_baud_end;

  assign data_ready = (r_state == S_IDLE) && !reset;
  assign w_accept   = data_valid && data_ready;
  assign w_baud_end = (r_baud == BAUD_LAST);
  assign tx         = r_tx;
  assign busy       = r_busy;

  // State and datapath registers; tx/busy are registered from the next-state values
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_stop  <= 1'b0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_stop  <= w_stop_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clock) begin
    if (reset)         r_parity <= 1'b0;
    else if (w_accept) r_parity <= ^data_in;
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = w_baud_end ? '0 : r_baud + CNT_W'(1);
    w_bit_nxt   = r_bit;
    w_stop_nxt  = r_stop;
    w_shift_nxt = r_shift;
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        if (w_accept) begin
          w_state_nxt = S_START;
          w_shift_nxt = data_in;
          w_bit_nxt   = '0;
          w_stop_nxt  = 1'b0;
        end
      end
      S_START: begin
        if (w_baud_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_baud_end) begin
          if (r_bit == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_bit_nxt   = r_bit + BIT_W'(1);
            w_shift_nxt = {1'b0, r_shift[DATA_WIDTH-1:1]};
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_baud_end) w_state_nxt = S_STOP;
      end
`endif
      S_STOP: begin
        if (w_baud_end) begin
          if (r_stop == STOP_LAST) w_state_nxt = S_IDLE;
          else                     w_stop_nxt  = r_stop + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Line level follows the state being entered so tx changes on the same edge as the state
  always_comb begin
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_tx_nxt   = 1'b1;
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_tx_nxt = r_parity;
`endif
      default:  w_tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx with a byte scoreboard and per-frame line decoding.
module tb_uart_tx;

  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NC = 11;
`else
  localparam int NC = 10;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       tx;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [7:0] sb[$];

  uart_tx #(
    .CLK_FREQ  (1_600_000),
    .BAUD_RATE (100_000),
    .DATA_WIDTH(8),
    .STOP_BITS (1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .tx        (tx),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  function automatic logic [NC-1:0] exp_frame(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction

  task automatic wait_start(input string tag, output int at);
    bit found = 0;
    at = cyc;
    for (int i = 0; i < 40 && !found; i++) begin
      if (tx === 1'b0) begin
        found = 1;
        at = cyc;
      end else tick();
    end
    check({tag, "_start_seen"}, 32'(found), 32'd1);
  endtask

  task automatic capture(input string tag);
    logic [NC-1:0] lv;
    logic [7:0]    eb;
    bit            stable;
    int            bcnt;
    int            rcnt;
    lv = '0; stable = 1; bcnt = 0; rcnt = 0;
    for (int i = 0; i < NC * CPB; i++) begin
      if (i % CPB == 0) lv[i / CPB] = tx;
      else if (tx !== lv[i / CPB]) stable = 0;
      if (busy === 1'b1) bcnt++;
      if (data_ready === 1'b1) rcnt++;
      tick();
    end
    check({tag, "_bit_hold"}, 32'(stable), 32'd1);
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'(NC * CPB));
    check({tag, "_ready_in_frame"}, 32'(rcnt), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_ready_after"}, 32'(data_ready), 32'd1);
    check({tag, "_tx_after"}, 32'(tx), 32'd1);
    check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      eb = sb.pop_front();
      check({tag, "_frame"}, 32'(lv), 32'(exp_frame(eb)));
    end
  endtask

  task automatic send_one(input string tag, input logic [7:0] b);
    int h;
    int s;
    data_in = b;
    data_valid = 1'b1;
    check({tag, "_ready_before"}, 32'(data_ready), 32'd1);
    sb.push_back(b);
    h = cyc;
    tick();
    data_valid = 1'b0;
    wait_start(tag, s);
    check({tag, "_start_latency"}, 32'(s - h), 32'd1);
    check({tag, "_busy_rise"}, 32'(busy), 32'd1);
    capture(tag);
  endtask

  initial begin
    int s1;
    int s2;
    int bad;
    reset = 1'b1;
    data_valid = 1'b0;
    data_in = 8'h00;

    // Reset for three cycles, then release
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(data_ready), 32'd0);
    end
    reset = 1'b0;
    #1;
    check("rel_ready", 32'(data_ready), 32'd1);
    check("rel_tx", 32'(tx), 32'd1);
    tick();
    check("rel_busy", 32'(busy), 32'd0);

    // Single frame 0xA5
    send_one("a5", 8'hA5);
    check("a5_pattern", 32'(exp_frame(8'hA5) & 10'h3FF), 32'(10'b1101001010));

    // Back-to-back 0x00 then 0xFF with valid held high
    data_in = 8'h00;
    data_valid = 1'b1;
    sb.push_back(8'h00);
    tick();
    data_in = 8'hFF;
    sb.push_back(8'hFF);
    wait_start("b2b0", s1);
    capture("b2b0");
    tick();
    data_valid = 1'b0;
    wait_start("b2b1", s2);
    check("b2b_spacing", 32'(s2 - s1), 32'd161);
    capture("b2b1");

    // 0x3C offered during a 0x81 frame is held off until the next IDLE cycle
    data_in = 8'h81;
    data_valid = 1'b1;
    sb.push_back(8'h81);
    tick();
    data_in = 8'h3C;
    wait_start("f81", s1);
    capture("f81");
    sb.push_back(8'h3C);
    tick();
    data_valid = 1'b0;
    wait_start("f3c", s2);
    check("f3c_spacing", 32'(s2 - s1), 32'd161);
    capture("f3c");

    // Reset at cycle 50 of a 0x0F frame, with valid asserted alongside reset
    data_in = 8'h0F;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    wait_start("f0f", s1);
    while (cyc - s1 < 50) tick();
    check("f0f_busy_mid", 32'(busy), 32'd1);
    reset = 1'b1;
    data_valid = 1'b1;
    tick();
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(data_ready), 32'd0);
    tick();
    reset = 1'b0;
    data_valid = 1'b0;
    #1;
    check("midrst_rel_ready", 32'(data_ready), 32'd1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("midrst_no_resume", 32'(bad), 32'd0);
    send_one("f96", 8'h96);

`ifdef UART_TX_PARITY_EN
    send_one("p07", 8'h07);
    send_one("p03", 8'h03);
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that serializes one parallel word per frame onto a single `tx` line: start bit, data LSB first, optional even parity, stop bit(s). It sits on the transmit side of the UART, opposite the oversampling receiver, and shares the same `CLK_FREQ`/`BAUD_RATE`/`DATA_WIDTH` parameter set so both ends agree on framing. Upstream logic hands words in through a valid/ready handshake; the block owns its own FSM, baud counter, bit counter and shift register.

## Interface

- `CLK_FREQ`, 100_000_000, system clock frequency in Hz
- `BAUD_RATE`, 115200, line rate in bits/s
- `DATA_WIDTH`, 8, data bits per frame (≥ 2)
- `STOP_BITS`, 1, stop bits per frame (1 or 2)

- `clock`  input  1  system clock, all logic on rising edge
- `reset`  input  1  synchronous, active-high reset
- `data_in`  input  DATA_WIDTH  word to transmit, sampled only on handshake
- `data_valid`  input  1  upstream has a word on `data_in`
- `data_ready`  output  1  block accepts a word this cycle
- `tx`  output  1  serial line, idle high, registered
- `busy`  output  1  frame in progress, registered

## Operation

- `CLKS_PER_BIT = CLK_FREQ / BAUD_RATE`, integer division, truncated; 868 at defaults. Baud counter width `$clog2(CLKS_PER_BIT)`, counts 0..CLKS_PER_BIT-1 then wraps.
- Bit counter width `$clog2(DATA_WIDTH)`; stop counter counts 0..STOP_BITS-1.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: `tx`=1, `busy`=0, `data_ready`=1. On `data_valid && data_ready`, latch `data_in` into the shift register, clear counters, go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: `tx` = shift register bit 0. Each bit is held CLKS_PER_BIT cycles, then shifted right. After bit DATA_WIDTH-1, go to PARITY (macro defined) or STOP.
- PARITY: `tx` = XOR of the latched word (even parity) for CLKS_PER_BIT cycles, then STOP.
- STOP: `tx`=1 for STOP_BITS × CLKS_PER_BIT cycles, then IDLE.
- `data_ready` = (state == IDLE) && !reset. `data_valid` outside IDLE is ignored; no queuing.
- `data_in` changes after the handshake have no effect on the frame in flight.

## Timing

- Reset values: state IDLE, `tx`=1, `busy`=0, counters and shift register 0. `data_ready`=0 while `reset`=1, and 1 on the first cycle after release.
- Handshake at edge k: `tx` falls and `busy` rises at cycle k+1. Both are registered.
- Frame length is (1 + DATA_WIDTH + P + STOP_BITS) × CLKS_PER_BIT cycles, where P = 1 with parity, else 0.
- After the last stop-bit cycle, the FSM spends exactly one IDLE cycle with `data_ready`=1. If `data_valid` is held high, the next start bit begins one cycle later. This gives a back-to-back start-to-start spacing of frame length + 1 cycles.
- Reset mid-frame: at the next edge `tx`=1, `busy`=0, state IDLE. The partial frame is abandoned and never resumed.
- Reset and `data_valid` in the same cycle: reset wins and the word is not accepted.

## Configuration

- `UART_TX_PARITY_EN` defined: the PARITY state is compiled in and one even-parity bit is sent between the data bits and the stop bit(s).
- Not defined: PARITY logic is absent, DATA goes directly to STOP, and the frame carries no parity bit.
- The receiver build must use the same setting.

## Test plan

Bench parameters: CLK_FREQ=1_600_000, BAUD_RATE=100_000 (CLKS_PER_BIT=16), DATA_WIDTH=8, STOP_BITS=1, parity off unless stated.

- Reset for 3 cycles, then release → `tx`=1 and `busy`=0 throughout; `data_ready`=0 during reset and 1 on the first cycle after.
- Send 0xA5 (one-cycle valid) → `tx` is 0,1,0,1,0,0,1,0,1,1, each level held exactly 16 cycles. `busy` is high for 160 cycles and `data_ready` returns on cycle 161.
- Hold `data_valid` high with 0x00 then 0xFF → the second start bit begins exactly 161 cycles after the first, and both frames decode correctly.
- Mid-frame, drive `data_in`=0x3C with `data_valid`=1 during a 0x81 frame → `data_ready` stays 0 and the line still carries 0x81. 0x3C is accepted only at the next IDLE cycle.
- Assert `reset` at cycle 50 of a 0x0F frame → `tx`=1 and `busy`=0 at the next edge. A following 0x96 frame is clean and correct.
- With `UART_TX_PARITY_EN`, send 0x07 → the parity bit is 1 and the frame lasts 176 cycles; send 0x03 → the parity bit is 0.
